// File: rtl/gbc_cart_ram_cache.sv
// gbc_cart_ram_cache: direct-mapped write-back cache between cartridge RAM accesses and a byte-wide backing port.
// Latency: hit accepted in the cycle Ready=1 (read data registered next Clk); miss costs LINE_BYTES acks, doubled for a dirty victim.
// Backpressure: Ready=0 outside IDLE; bursts hold BkReq and advance only on BkAck. Define CART_RAM_FLUSH_EN for Flush/FlushBusy.
module gbc_cart_ram_cache #(
   parameter int LINES      = 16,
   parameter int LINE_BYTES = 16,
   parameter int WB_PERIOD  = 512,
   parameter int ADDR_W     = 17
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ClkEn,
   input  logic              Access,
   input  logic              Write,
   input  logic [ADDR_W-1:0] Address,
   input  logic [7:0]        WrData,
   output logic [7:0]        RdData,
   output logic              Ready,
   output logic              BkReq,
   output logic              BkWrite,
   output logic [ADDR_W-1:0] BkAddr,
   output logic [7:0]        BkWData,
   input  logic [7:0]        BkRData,
   input  logic              BkAck,
   output logic              SaveNotify,
   output logic [ADDR_W-1:0] SaveAddr
`ifdef CART_RAM_FLUSH_EN
   ,
   input  logic              Flush,
   output logic              FlushBusy
`endif
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int TMR_W = (WB_PERIOD > 1) ? $clog2(WB_PERIOD) : 1;

   typedef enum logic [2:0] {
      IDLE, EVICT, FILL, SCRUB
`ifdef CART_RAM_FLUSH_EN
      , FLUSH_SCAN, FLUSH_WB
`endif
   } state_t;

   state_t state, state_n;

   // Line storage: data and tags carry no reset, valid/dirty do.
   logic [7:0]       mem     [LINES*LINE_BYTES];
   logic [TAG_W-1:0] tag_arr [LINES];
   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;

   // Burst context: which line is moving and which byte is next.
   logic [IDX_W-1:0] bk_idx;
   logic [TAG_W-1:0] bk_tag;
   logic [TAG_W-1:0] fill_tag;
   logic [OFF_W-1:0] cnt;

   logic [TMR_W-1:0] timer;
   logic [IDX_W-1:0] scrub_ptr;
   logic             scrub_pending;
   logic [7:0]       rd_data;
   logic             save_notify;
   logic [ADDR_W-1:0] save_addr;

   logic [OFF_W-1:0] a_off;
   logic [IDX_W-1:0] a_idx;
   logic [TAG_W-1:0] a_tag;
   logic             hit;
   logic             last;
   logic             timer_wrap;

   // Control strobes from the next-state logic.
   logic ready, bk_req, bk_write;
   logic miss_go, scrub_step, wb_done, fill_done;

`ifdef CART_RAM_FLUSH_EN
   logic [IDX_W-1:0] flush_ptr;
   logic             flush_pending;
   logic             flush_req;
   logic             flush_go, flush_next, flush_wb_go;
   assign flush_req = Flush | flush_pending;
   assign FlushBusy = (state == FLUSH_SCAN) || (state == FLUSH_WB);
`endif

   assign a_off      = Address[OFF_W-1:0];
   assign a_idx      = Address[OFF_W +: IDX_W];
   assign a_tag      = Address[ADDR_W-1 -: TAG_W];
   assign hit        = valid[a_idx] && (tag_arr[a_idx] == a_tag);
   assign last       = (cnt == OFF_W'(LINE_BYTES-1));
   assign timer_wrap = (timer == TMR_W'(WB_PERIOD-1));

   assign Ready      = ready;
   assign BkReq      = bk_req;
   assign BkWrite    = bk_write;
   assign BkAddr     = {bk_tag, bk_idx, cnt};
   assign BkWData    = mem[{bk_idx, cnt}];
   assign RdData     = rd_data;
   assign SaveNotify = save_notify;
   assign SaveAddr   = save_addr;

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state, handshake outputs and burst strobes.
   always_comb begin
      state_n    = state;
      ready      = 1'b0;
      bk_req     = 1'b0;
      bk_write   = 1'b0;
      miss_go    = 1'b0;
      scrub_step = 1'b0;
      wb_done    = 1'b0;
      fill_done  = 1'b0;
`ifdef CART_RAM_FLUSH_EN
      flush_go    = 1'b0;
      flush_next  = 1'b0;
      flush_wb_go = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef CART_RAM_FLUSH_EN
            if (flush_req) begin
               flush_go = 1'b1;
               state_n  = FLUSH_SCAN;
            end else
`endif
            if (ClkEn && Access) begin
               if (hit) begin
                  ready = 1'b1;
               end else begin
                  miss_go = 1'b1;
                  state_n = (valid[a_idx] && dirty[a_idx]) ? EVICT : FILL;
               end
            end else if (scrub_pending && !Access) begin
               // Scrub step consumes the pending bit even when the line is clean.
               scrub_step = 1'b1;
               if (dirty[scrub_ptr]) state_n = SCRUB;
            end
         end
         EVICT: begin
            bk_req   = 1'b1;
            bk_write = 1'b1;
            if (BkAck && last) begin
               wb_done = 1'b1;
               state_n = FILL;
            end
         end
         FILL: begin
            bk_req = 1'b1;
            if (BkAck && last) begin
               fill_done = 1'b1;
               state_n   = IDLE;
            end
         end
         SCRUB: begin
            bk_req   = 1'b1;
            bk_write = 1'b1;
            if (BkAck && last) begin
               wb_done = 1'b1;
               state_n = IDLE;
            end
         end
`ifdef CART_RAM_FLUSH_EN
         FLUSH_SCAN: begin
            if (dirty[flush_ptr]) begin
               flush_wb_go = 1'b1;
               state_n     = FLUSH_WB;
            end else if (flush_ptr == IDX_W'(LINES-1)) begin
               state_n = IDLE;
            end else begin
               flush_next = 1'b1;
            end
         end
         FLUSH_WB: begin
            bk_req   = 1'b1;
            bk_write = 1'b1;
            if (BkAck && last) begin
               wb_done = 1'b1;
               if (flush_ptr == IDX_W'(LINES-1)) begin
                  state_n = IDLE;
               end else begin
                  flush_next = 1'b1;
                  state_n    = FLUSH_SCAN;
               end
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // Line data and tags: written by hit writes and by fill acks.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (ready && Write)
            mem[{a_idx, a_off}] <= WrData;
         if (state == FILL && BkAck)
            mem[{bk_idx, cnt}] <= BkRData;
         if (fill_done)
            tag_arr[bk_idx] <= bk_tag;
      end
   end

   // Line state, burst context, scrub timer and host-visible registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid         <= '0;
         dirty         <= '0;
         bk_idx        <= '0;
         bk_tag        <= '0;
         fill_tag      <= '0;
         cnt           <= '0;
         timer         <= '0;
         scrub_ptr     <= '0;
         scrub_pending <= 1'b0;
         rd_data       <= 8'h00;
         save_notify   <= 1'b0;
         save_addr     <= '0;
`ifdef CART_RAM_FLUSH_EN
         flush_ptr     <= '0;
         flush_pending <= 1'b0;
`endif
      end else begin
         save_notify <= 1'b0;
         timer       <= timer_wrap ? '0 : timer + TMR_W'(1);

         // A new wrap wins over consumption; a wrap while pending just merges.
         if (timer_wrap)      scrub_pending <= 1'b1;
         else if (scrub_step) scrub_pending <= 1'b0;

         if (ready && !Write) rd_data <= mem[{a_idx, a_off}];
         if (ready && Write)  dirty[a_idx] <= 1'b1;

         if (miss_go) begin
            bk_idx   <= a_idx;
            fill_tag <= a_tag;
            cnt      <= '0;
            bk_tag   <= (valid[a_idx] && dirty[a_idx]) ? tag_arr[a_idx] : a_tag;
         end

         if (scrub_step) begin
            bk_idx    <= scrub_ptr;
            bk_tag    <= tag_arr[scrub_ptr];
            cnt       <= '0;
            scrub_ptr <= scrub_ptr + IDX_W'(1);
         end

         // Byte counter wraps back to zero at the end of each burst.
         if (bk_req && BkAck) cnt <= cnt + OFF_W'(1);

         if (wb_done) begin
            dirty[bk_idx] <= 1'b0;
            save_notify   <= 1'b1;
            save_addr     <= {bk_tag, bk_idx, {OFF_W{1'b0}}};
            if (state == EVICT) bk_tag <= fill_tag;
         end

         if (fill_done) begin
            valid[bk_idx] <= 1'b1;
            dirty[bk_idx] <= 1'b0;
         end

`ifdef CART_RAM_FLUSH_EN
         if (flush_go)           flush_pending <= 1'b0;
         else if (Flush)         flush_pending <= 1'b1;
         if (flush_go)   flush_ptr <= '0;
         if (flush_next) flush_ptr <= flush_ptr + IDX_W'(1);
         if (flush_wb_go) begin
            bk_idx <= flush_ptr;
            bk_tag <= tag_arr[flush_ptr];
            cnt    <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_gbc_cart_ram_cache.sv
// tb_gbc_cart_ram_cache: directed vectors plus hand-built sequences for scrub, coincidence and reset abort.
// Backing memory model answers the Bk port and logs every transfer and SaveNotify pulse.
// Clock period 10; inputs driven 3 after the falling edge, outputs sampled there too.
module tb_gbc_cart_ram_cache;

   logic        clk = 1'b0;
   logic        rst, clk_en, access, wr;
   logic [16:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rd_data;
   logic        ready, bk_req, bk_write, bk_ack, save_notify;
   logic [16:0] bk_addr, save_addr;
   logic [7:0]  bk_wdata, bk_rdata;

   always #5 clk = ~clk;

   gbc_cart_ram_cache #(.LINES(16), .LINE_BYTES(16), .WB_PERIOD(512), .ADDR_W(17)) dut (
      .Clk(clk), .Reset(rst), .ClkEn(clk_en), .Access(access), .Write(wr),
      .Address(addr), .WrData(wdata), .RdData(rd_data), .Ready(ready),
      .BkReq(bk_req), .BkWrite(bk_write), .BkAddr(bk_addr), .BkWData(bk_wdata),
      .BkRData(bk_rdata), .BkAck(bk_ack), .SaveNotify(save_notify), .SaveAddr(save_addr)
   );

   int checks = 0, failures = 0;
   logic [7:0] bk_mem [0:131071];
   int cyc = 0;
   int rd_cnt, wr_cnt, sn_cnt, proto_err = 0;
   int first_wr_cyc, last_rd_cyc;
   logic [16:0] rd_q[$], wr_q[$], sn_q[$];
   bit ack_rand = 1'b0;

   logic        pend_req = 1'b0, pend_wr = 1'b0;
   logic [16:0] pend_addr = '0;
   logic [7:0]  pend_dat = '0;
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_wr = 1'b0;
   logic [16:0] prev_addr = '0;
   logic [7:0]  prev_dat = '0;

   initial bk_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Backing side: decide ack, present read data, watch burst stability and SaveNotify.
   always @(negedge clk) begin
      #2;
      bk_ack    = bk_req && (!ack_rand || ($urandom_range(0, 1) == 1));
      bk_rdata  = bk_mem[bk_addr];
      if (prev_req && bk_req && !prev_ack &&
          (bk_addr !== prev_addr || bk_write !== prev_wr || (bk_write && bk_wdata !== prev_dat)))
         proto_err++;
      prev_req  = bk_req;  prev_ack = bk_ack;  prev_wr = bk_write;
      prev_addr = bk_addr; prev_dat = bk_wdata;
      pend_req  = bk_req && bk_ack;
      pend_wr   = bk_write; pend_addr = bk_addr; pend_dat = bk_wdata;
      if (save_notify === 1'b1) begin
         sn_cnt++;
         sn_q.push_back(save_addr);
      end
   end

   // Commit the transfer decided on the falling edge (dropped if reset is being applied).
   always @(posedge clk) begin
      if (rst) cyc = 0; else cyc++;
      if (pend_req && !rst) begin
         if (pend_wr) begin
            bk_mem[pend_addr] = pend_dat;
            wr_cnt++;
            wr_q.push_back(pend_addr);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
         end else begin
            rd_cnt++;
            rd_q.push_back(pend_addr);
            last_rd_cyc = cyc;
         end
      end
      pend_req = 1'b0;
   end

   task automatic clr();
      rd_cnt = 0; wr_cnt = 0; sn_cnt = 0;
      rd_q.delete(); wr_q.delete(); sn_q.delete();
      first_wr_cyc = -1; last_rd_cyc = -1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 131072; i++) bk_mem[i] = i[7:0];
      rst = 1'b1; access = 1'b0; wr = 1'b0; addr = '0; wdata = '0; clk_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #3;
      rst = 1'b0;
      clr();
   endtask

   task automatic do_access(input bit w, input logic [16:0] a, input logic [7:0] d, output logic [7:0] rd);
      int n;
      access = 1'b1; wr = w; addr = a; wdata = d;
      #1;
      n = 0;
      while (!ready && n < 2000) begin
         @(negedge clk); #3;
         n++;
      end
      chk($sformatf("ready_within_budget addr=%0h", a), ready, 1);
      if (ready !== 1'b1) begin
         access = 1'b0;
         rd = 8'h00;
         return;
      end
      @(posedge clk);
      @(negedge clk); #3;
      rd = rd_data;
      access = 1'b0;
   endtask

   typedef struct {
      bit          w;
      logic [16:0] a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      int          nrd;
      int          nwr;
      int          nsn;
      logic [16:0] ebase;
   } vec_t;

   vec_t vec [11];

   initial begin
      logic [7:0]  rdv;
      logic [16:0] base;
      int errs, n;

      vec[0]  = '{0, 17'h00005, 8'h00, 8'h05, 16, 0,  0, 17'h00000};
      vec[1]  = '{1, 17'h00005, 8'hA5, 8'h00, 0,  0,  0, 17'h00000};
      vec[2]  = '{0, 17'h00005, 8'h00, 8'hA5, 0,  0,  0, 17'h00000};
      vec[3]  = '{0, 17'h00105, 8'h00, 8'h05, 16, 16, 1, 17'h00000};
      vec[4]  = '{0, 17'h00005, 8'h00, 8'hA5, 16, 0,  0, 17'h00000};
      vec[5]  = '{1, 17'h1F0FF, 8'h77, 8'h00, 16, 0,  0, 17'h00000};
      vec[6]  = '{0, 17'h1F0FF, 8'h00, 8'h77, 0,  0,  0, 17'h00000};
      vec[7]  = '{0, 17'h1F0F3, 8'h00, 8'hF3, 0,  0,  0, 17'h00000};
      vec[8]  = '{1, 17'h1F0F3, 8'h11, 8'h00, 0,  0,  0, 17'h00000};
      vec[9]  = '{0, 17'h000F0, 8'h00, 8'hF0, 16, 16, 1, 17'h1F0F0};
      vec[10] = '{0, 17'h1F0F3, 8'h00, 8'h11, 16, 0,  0, 17'h00000};

      // Reset state.
      do_reset();
      chk("reset ready", ready, 0);
      chk("reset rddata", rd_data, 8'h00);
      chk("reset bkreq", bk_req, 0);
      chk("reset savenotify", save_notify, 0);
      chk("reset saveaddr", save_addr, 17'h0);

      // Directed vectors.
      for (int i = 0; i < 11; i++) begin
         clr();
         do_access(vec[i].w, vec[i].a, vec[i].d, rdv);
         if (!vec[i].w) chk($sformatf("v%0d rddata", i), rdv, vec[i].exp_rd);
         chk($sformatf("v%0d bk_reads", i), rd_cnt, vec[i].nrd);
         chk($sformatf("v%0d bk_writes", i), wr_cnt, vec[i].nwr);
         chk($sformatf("v%0d savenotify", i), sn_cnt, vec[i].nsn);
         base = {vec[i].a[16:4], 4'h0};
         errs = 0;
         foreach (rd_q[k]) if (rd_q[k] !== base + 17'(k)) errs++;
         foreach (wr_q[k]) if (wr_q[k] !== vec[i].ebase + 17'(k)) errs++;
         foreach (sn_q[k]) if (sn_q[k] !== vec[i].ebase) errs++;
         chk($sformatf("v%0d bk_addr_seq", i), errs, 0);
      end
      chk("evicted byte 5", bk_mem[17'h00005], 8'hA5);
      chk("evicted byte 4", bk_mem[17'h00004], 8'h04);
      chk("evicted 1F0FF", bk_mem[17'h1F0FF], 8'h77);
      chk("evicted 1F0F3", bk_mem[17'h1F0F3], 8'h11);

      // Front-end qualifiers on a line now resident.
      access = 1'b1; wr = 1'b0; addr = 17'h1F0F3; clk_en = 1'b0; #1;
      chk("clken low ready", ready, 0);
      clk_en = 1'b1; #1;
      chk("hit ready", ready, 1);
      access = 1'b0; #1;
      chk("no access ready", ready, 0);

      // Background scrub writes one dirty line exactly once.
      do_reset();
      do_access(1, 17'h00020, 8'h3C, rdv);
      clr();
      repeat (2 * 512 * 16) @(negedge clk);
      #3;
      chk("scrub writes", wr_cnt, 16);
      chk("scrub reads", rd_cnt, 0);
      chk("scrub savenotify", sn_cnt, 1);
      chk("scrub saveaddr", (sn_q.size() > 0) ? sn_q[0] : 17'h1FFFF, 17'h00020);
      errs = 0;
      foreach (wr_q[k]) if (wr_q[k] !== 17'h00020 + 17'(k)) errs++;
      chk("scrub addr seq", errs, 0);
      chk("scrub data 20", bk_mem[17'h00020], 8'h3C);
      chk("scrub data 21", bk_mem[17'h00021], 8'h21);

      // Timer wrap coincides with a read miss: fill first, scrub of line 0 afterwards.
      do_reset();
      do_access(1, 17'h00003, 8'h99, rdv);
      while (cyc < 511) begin @(negedge clk); #3; end
      clr();
      do_access(0, 17'h00040, 8'h00, rdv);
      repeat (40) @(negedge clk);
      #3;
      chk("coincide rddata", rdv, 8'h40);
      chk("coincide reads", rd_cnt, 16);
      chk("coincide writes", wr_cnt, 16);
      chk("coincide order", (first_wr_cyc > last_rd_cyc) ? 1 : 0, 1);
      chk("coincide savenotify", sn_cnt, 1);
      chk("coincide saveaddr", (sn_q.size() > 0) ? sn_q[0] : 17'h1FFFF, 17'h00000);
      chk("coincide first wr addr", (wr_q.size() > 0) ? wr_q[0] : 17'h1FFFF, 17'h00000);
      chk("coincide data 3", bk_mem[17'h00003], 8'h99);

      // Reset after the 7th fill ack aborts the burst and leaves the line invalid.
      do_reset();
      ack_rand = 1'b1;
      access = 1'b1; wr = 1'b0; addr = 17'h00085;
      n = 0;
      while (rd_cnt < 7 && n < 500) begin @(negedge clk); #3; n++; end
      chk("abort seven acks", rd_cnt, 7);
      chk("abort bkreq mid burst", bk_req, 1);
      rst = 1'b1; access = 1'b0;
      @(negedge clk); #3;
      chk("abort bkreq after reset", bk_req, 0);
      @(negedge clk); #3;
      rst = 1'b0;
      ack_rand = 1'b0;
      clr();
      do_access(0, 17'h00085, 8'h00, rdv);
      chk("abort reread rddata", rdv, 8'h85);
      chk("abort reread misses", rd_cnt, 16);

      chk("burst stable between acks", proto_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
